immediate_pack: RTL and testbench

//  Inverse of immediate decoding: scatters a 32-bit immediate into the I/S/B/U/J bit slots
//  of an instruction word whose non-immediate fields (opcode, rd, rs1, rs2, funct3, funct7)

---
 rtl/immediate_pack.sv | 149 ++++++++++++++
 tb/tb_immediate_pack.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/immediate_pack.sv
// Packs an immediate into the I/S/B/U/J slots of a pre-filled instruction word, flagging
// unrepresentable immediates; two-stage valid/ready pipe. Optional counter: IMMEDIATE_PACK_ERR_CNT_EN.
module immediate_pack #(
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [31:0]          in_base,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [1:0]           out_err_code,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [2:0] FmtI = 3'd0;
    localparam logic [2:0] FmtS = 3'd1;
    localparam logic [2:0] FmtB = 3'd2;
    localparam logic [2:0] FmtU = 3'd3;
    localparam logic [2:0] FmtJ = 3'd4;

    localparam logic [1:0] ErrOk    = 2'd0;
    localparam logic [1:0] ErrRange = 2'd1;
    localparam logic [1:0] ErrAlign = 2'd2;
    localparam logic [1:0] ErrFmt   = 2'd3;

    logic        s1_valid_q;
    logic [2:0]  s1_fmt_q;
    logic [31:0] s1_base_q;
    logic [31:0] s1_imm_q;
    logic [1:0]  s1_code_q;
    logic        s1_ready;

    logic        s2_valid_q;
    logic [31:0] s2_instr_q;
    logic [1:0]  s2_code_q;
    logic        s2_ready;

    logic [1:0]  code_d;
    logic [31:0] packed_d;
    logic        rng_is;
    logic        rng_b;
    logic        rng_j;

    assign s2_ready = !s2_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_ready = s1_ready;

    // Out of range when the sign-extension bits above the slot are not all equal.
    assign rng_is = !((&in_imm[31:11]) || !(|in_imm[31:11]));
    assign rng_b  = !((&in_imm[31:12]) || !(|in_imm[31:12]));
    assign rng_j  = !((&in_imm[31:20]) || !(|in_imm[31:20]));

    always_comb begin
        code_d = ErrOk;
        case (in_fmt)
            FmtI, FmtS: code_d = rng_is ? ErrRange : ErrOk;
            FmtB:       code_d = in_imm[0] ? ErrAlign : (rng_b ? ErrRange : ErrOk);
            FmtJ:       code_d = in_imm[0] ? ErrAlign : (rng_j ? ErrRange : ErrOk);
            FmtU:       code_d = (|in_imm[11:0]) ? ErrRange : ErrOk;
            default:    code_d = ErrFmt;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_fmt_q   <= '0;
            s1_base_q  <= '0;
            s1_imm_q   <= '0;
            s1_code_q  <= '0;
        end else if (s1_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_fmt_q  <= in_fmt;
                s1_base_q <= in_base;
                s1_imm_q  <= in_imm;
                s1_code_q <= code_d;
            end
        end
    end

    // Errored words still pack their truncated slots; bad formats pass the base through.
    always_comb begin
        packed_d = s1_base_q;
        case (s1_fmt_q)
            FmtI: packed_d[31:20] = s1_imm_q[11:0];
            FmtS: begin
                packed_d[31:25] = s1_imm_q[11:5];
                packed_d[11:7]  = s1_imm_q[4:0];
            end
            FmtB: begin
                packed_d[31]    = s1_imm_q[12];
                packed_d[30:25] = s1_imm_q[10:5];
                packed_d[11:8]  = s1_imm_q[4:1];
                packed_d[7]     = s1_imm_q[11];
            end
            FmtU: packed_d[31:12] = s1_imm_q[31:12];
            FmtJ: begin
                packed_d[31]    = s1_imm_q[20];
                packed_d[30:21] = s1_imm_q[10:1];
                packed_d[20]    = s1_imm_q[11];
                packed_d[19:12] = s1_imm_q[19:12];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_code_q  <= '0;
        end else if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_q <= packed_d;
                s2_code_q  <= s1_code_q;
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_instr    = s2_instr_q;
    assign out_err_code = s2_code_q;
    assign out_err      = |s2_code_q;

`ifdef IMMEDIATE_PACK_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt_q <= '0;
        end else if (out_valid && out_ready && out_err && !(&err_cnt_q)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_immediate_pack.sv
// Scoreboard bench for immediate_pack: driver pushes expected words on accept, monitor pops on
// delivery. Honours IMMEDIATE_PACK_ERR_CNT_EN for the error-counter expectations.
module tb_immediate_pack;

    localparam int ERR_CNT_W = 16;

    typedef struct packed {
        logic [31:0] instr;
        logic [1:0]  code;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_fmt;
    logic [31:0]          in_base;
    logic [31:0]          in_imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_instr;
    logic                 out_err;
    logic [1:0]           out_err_code;
    logic [ERR_CNT_W-1:0] err_cnt;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   exp_errs = 0;
    int   ready_mode = 1;  // 0 stall, 1 always ready, 2 random

    immediate_pack #(.ERR_CNT_W(ERR_CNT_W)) dut (
        .clk(clk),
        .rstn(rstn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_fmt(in_fmt),
        .in_base(in_base),
        .in_imm(in_imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_err(out_err),
        .out_err_code(out_err_code),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: range as signed intervals, packing as masks and shifts.
    function automatic exp_t model(input logic [2:0] f, input logic [31:0] b,
                                   input logic [31:0] imm);
        exp_t e;
        int   s;
        s = $signed(imm);
        e.code = 2'd0;
        case (f)
            3'd0: begin
                e.instr = (b & 32'h000FFFFF) | (imm << 20);
                if (s < -2048 || s > 2047) e.code = 2'd1;
            end
            3'd1: begin
                e.instr = (b & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) |
                          ((imm & 32'h1F) << 7);
                if (s < -2048 || s > 2047) e.code = 2'd1;
            end
            3'd2: begin
                e.instr = (b & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31) |
                          (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8) |
                          (((imm >> 11) & 32'h1) << 7);
                if (imm % 2 != 0) e.code = 2'd2;
                else if (s < -4096 || s > 4095) e.code = 2'd1;
            end
            3'd3: begin
                e.instr = (b & 32'h00000FFF) | (imm & 32'hFFFFF000);
                if (imm % 4096 != 0) e.code = 2'd1;
            end
            3'd4: begin
                e.instr = (b & 32'h00000FFF) | (((imm >> 20) & 32'h1) << 31) |
                          (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20) |
                          (imm & 32'h000FF000);
                if (imm % 2 != 0) e.code = 2'd2;
                else if (s < -(1 << 20) || s > (1 << 20) - 1) e.code = 2'd1;
            end
            default: begin
                e.instr = b;
                e.code  = 2'd3;
            end
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [2:0] f, input logic [31:0] b, input logic [31:0] imm,
                        input exp_t e);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_fmt   = f;
        in_base  = b;
        in_imm   = imm;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready stayed 0 for 200 cycles at %0t", $time);
        end
    endtask

    task automatic send_model(input logic [2:0] f, input logic [31:0] b, input logic [31:0] imm);
        send(f, b, imm, model(f, b, imm));
    endtask

    task automatic drain();
        ready_mode = 1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        tick();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic rand_word(output logic [2:0] f, output logic [31:0] b, output logic [31:0] imm);
        f = ($urandom % 8 == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        b = $urandom;
        case ($urandom % 4)
            0: imm = $urandom;
            1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: imm = $urandom & 32'hFFFFF000;
            default: imm = 32'($urandom_range(0, (1 << 21) - 1)) - 32'd1048576;
        endcase
        if ($urandom % 4 != 0) imm[0] = 1'b0;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            tick();
            case (ready_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: out_ready = ($urandom % 4) != 0;
            endcase
        end
    end

    // Monitor: pops on each output transfer and checks hold-while-stalled.
    initial begin
        exp_t        e;
        bit          stalled;
        logic [31:0] p_instr;
        logic [1:0]  p_code;
        stalled = 0;
        p_instr = '0;
        p_code  = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_instr", out_instr, p_instr);
                    check("hold_code", 32'(out_err_code), 32'(p_code));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_word: got %h expected none", out_instr);
                    end else begin
                        e = sb.pop_front();
                        check("out_instr", out_instr, e.instr);
                        check("out_err_code", 32'(out_err_code), 32'(e.code));
                        check("out_err", 32'(out_err), 32'(e.code != 2'd0));
                        if (e.code != 2'd0) exp_errs++;
                    end
                end
                stalled = out_valid && !out_ready;
                p_instr = out_instr;
                p_code  = out_err_code;
            end
        end
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] b;
        logic [31:0] imm;
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_fmt   = '0;
        in_base  = '0;
        in_imm   = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_code", 32'(out_err_code), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        tick();

        // Directed vectors with hand-computed expectations.
        send(3'd0, 32'h00000013, 32'hFFFFFFFF, '{instr: 32'hFFF00013, code: 2'd0});
        @(negedge clk);
        check("latency_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_cycle2", 32'(out_valid), 32'd1);
        tick();
        send(3'd2, 32'h00000063, 32'hFFFFFFFC, '{instr: 32'hFE000EE3, code: 2'd0});
        send(3'd4, 32'h0000006F, 32'h00000008, '{instr: 32'h0080006F, code: 2'd0});
        send(3'd0, 32'h00000013, 32'h00000800, '{instr: 32'h80000013, code: 2'd1});
        send(3'd2, 32'h00000063, 32'h00000005, '{instr: 32'h00000263, code: 2'd2});
        send(3'd7, 32'h12345678, 32'h00000004, '{instr: 32'h12345678, code: 2'd3});
        drain();
`ifdef IMMEDIATE_PACK_ERR_CNT_EN
        check("err_cnt_directed", 32'(err_cnt), 32'd3);
`else
        check("err_cnt_directed", 32'(err_cnt), 32'd0);
`endif

        // Stall: two words fill the pipe, the third must wait.
        ready_mode = 0;
        tick();
        tick();
        rand_word(f, b, imm);
        send_model(f, b, imm);
        rand_word(f, b, imm);
        send_model(f, b, imm);
        rand_word(f, b, imm);
        in_valid = 1'b1;
        in_fmt   = f;
        in_base  = b;
        in_imm   = imm;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        check("stall_depth", 32'(sb.size()), 32'd2);
        ready_mode = 1;
        send_model(f, b, imm);
        drain();

        // Reset with two words in flight.
        ready_mode = 0;
        tick();
        tick();
        rand_word(f, b, imm);
        send_model(f, b, imm);
        rand_word(f, b, imm);
        send_model(f, b, imm);
        rstn = 1'b0;
        #1;
        check("rst_flush_valid", 32'(out_valid), 32'd0);
        check("rst_flush_err_cnt", 32'(err_cnt), 32'd0);
        sb.delete();
        exp_errs = 0;
        ready_mode = 1;
        tick();
        rstn = 1'b1;
        tick();
        @(negedge clk);
        check("in_ready_after_rst2", 32'(in_ready), 32'd1);
        tick();
        send_model(3'd3, 32'h00000037, 32'h12345000);
        @(negedge clk);
        check("post_rst_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("post_rst_cycle2", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("post_rst_alone", 32'(out_valid), 32'd0);
        tick();

        // Randomized traffic with random back-pressure.
        ready_mode = 2;
        for (int n = 0; n < 300; n++) begin
            rand_word(f, b, imm);
            send_model(f, b, imm);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
`ifdef IMMEDIATE_PACK_ERR_CNT_EN
        check("err_cnt_final", 32'(err_cnt), 32'(exp_errs));
`else
        check("err_cnt_final", 32'(err_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
